urv_dm_responder: RTL and testbench
===================================

# urv_dm_responder

Data-memory responder for the uRV core's `dm_*` load/store port: the target end of the interface the CPU drives as initiator. Holds a byte-laned word SRAM, a console output register and programmable wait states. Replaces the ad-hoc memory/IO logic in system benches. It is synthesizable so the same block serves simulation and FPGA builds.

## Interface
- `ADDR_BITS`, default 12: word-address width; memory depth is 2**ADDR_BITS 32-bit words.
- `WAIT_STATES`, default 0: extra cycles inserted per access, range 0..15.
- `CONSOLE_ADDR`, default 32'h1000_0000: byte address of the console register.
- `wclk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `dm_addr_i`  in  32  byte address from the CPU; bits [1:0] ignored.
- `dm_data_s_i`  in  32  store data.
- `dm_data_select_i`  in  4  byte-lane enables; bit n selects `dm_data_s_i[8n+7:8n]`.
- `dm_store_i`  in  1  store request.
- `dm_load_i`  in  1  load request.
- `dm_data_l_o`  out  32  load data; valid only while `dm_load_done_o`=1.
- `dm_load_done_o`  out  1  one-cycle load completion pulse.
- `dm_store_done_o`  out  1  one-cycle store completion pulse.
- `dm_ready_o`  out  1  high when a new request can be accepted.
- `console_data_o`  out  8  last byte written to the console.
- `console_valid_o`  out  1  one-cycle pulse per console write.
- `halt_o`  out  1  sticky; set by a console write of 8'hFF.
- `err_o`  out  1  sticky; set by an access outside memory and outside the console.

## Operation
- Acceptance: a request is accepted at a rising `wclk` edge where `dm_ready_o`=1 and (`dm_store_i` | `dm_load_i`). Address, data and select are captured at that edge.
- Decode:
  - Memory hit when `dm_addr_i[31:ADDR_BITS+2]`==0; the word index is `dm_addr_i[ADDR_BITS+1:2]`.
  - Console hit when `dm_addr_i`==`CONSOLE_ADDR`.
  - Anything else is out-of-range.
- Memory store: writes only the enabled byte lanes; the other lanes keep their values. Select 4'b0000 writes nothing but still completes.
- Memory load: returns the full word regardless of select.
- Simultaneous load and store: the store is performed. Both done pulses fire together. `dm_data_l_o` returns the word as it was before the store (read-before-write).
- Console store: when `dm_data_select_i[0]`=1, `console_data_o` ← data[7:0] and `console_valid_o` pulses. If data[7:0]==8'hFF, `halt_o` is also set. Console load returns 32'h0.
- Out-of-range: the store is dropped, a load returns 32'h0, `err_o` is set. The access still completes with normal timing.
- FSM states:
  - IDLE: `dm_ready_o`=1. On accept, go to WAIT if `WAIT_STATES`>0, else DONE.
  - WAIT: a 4-bit counter counts `WAIT_STATES` cycles, then goes to DONE.
  - DONE: done pulse(s) asserted. When `WAIT_STATES`=0, DONE overlaps IDLE so a new request can be accepted in the same cycle.
- Reset: memory contents are not reset. Every output is 0 except `dm_ready_o`, which is 1. The FSM goes to IDLE. An in-flight access is abandoned with no done pulse; a pending store may or may not have committed.

## Timing
- Accept at edge A → done pulse in the cycle after edge A+`WAIT_STATES`. Latency is `WAIT_STATES`+1 cycles.
- `dm_ready_o` is low for the `WAIT_STATES` cycles following edge A and returns high in the done cycle.
- With `WAIT_STATES`=0, `dm_ready_o` stays 1 and back-to-back requests are accepted every cycle (one completion per cycle).
- A load immediately after a store to the same word returns the stored data.
- All outputs are registered. `console_valid_o` is coincident with `dm_store_done_o`.
- `halt_o` and `err_o` rise in the done cycle and hold until reset.

## Configuration
- `URV_DM_CONSOLE_EN` defined: console decode, `console_*` and `halt_o` behave as described above.
- `URV_DM_CONSOLE_EN` undefined: no console decode. `CONSOLE_ADDR` is treated as an ordinary address, which is out-of-range unless it lies inside memory. `console_data_o`, `console_valid_o` and `halt_o` are tied to 0.

## Test plan
- `WAIT_STATES`=0: store 32'hA5A5_1234 at 0x10 with select 4'hF, then load 0x10 on the next cycle → load_done 1 cycle after accept, data 32'hA5A5_1234; `dm_ready_o` never drops.
- Byte lanes: word 0x20 = 32'h1122_3344; store 32'hFFEE_DDCC with select 4'b0101 → load returns 32'h11EE_33CC.
- `WAIT_STATES`=3: a single load → `dm_ready_o` low for 3 cycles, load_done exactly 4 cycles after accept; a request held during the low cycles is accepted at the first edge with ready high.
- Console (macro on): stores of 8'h48 then 8'hFF to 0x1000_0000 → two `console_valid_o` pulses with data 8'h48 and 8'hFF; `halt_o`=1 after the second. With the macro off, the same stores set `err_o` and produce no console pulses.
- Out-of-range store to 0x2000_0000 → `dm_store_done_o` pulses, memory unchanged, `err_o`=1 and stays 1.
- Assert `rst` low while in WAIT (`WAIT_STATES`=5) → no done pulse, `dm_ready_o`=1, other outputs 0; after release, a load of a previously written word returns its data.

Source files
------------

// File: rtl/urv_dm_responder.sv
// urv_dm_responder: uRV dm_* target holding a byte-laned word SRAM, console register and wait states.
// Latency: WAIT_STATES+1 cycles from the accept edge to the done pulse(s); all outputs registered.
// Backpressure: dm_ready_o drops for WAIT_STATES cycles after an accept; stays high when WAIT_STATES=0.
// Optional console decode (console_*, halt_o) is built when URV_DM_CONSOLE_EN is defined.
module urv_dm_responder #(
  parameter int          ADDR_BITS    = 12,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000
) (
  input  logic        wclk,
  input  logic        rst,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_ready_o,
  output logic [7:0]  console_data_o,
  output logic        console_valid_o,
  output logic        halt_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  sel_q;
  logic        ld_q;
  logic        st_q;

  logic [31:0] mem [2**ADDR_BITS];

  logic                 accept;
  logic                 fire;
  logic [31:0]          a_addr;
  logic [31:0]          a_data;
  logic [3:0]           a_sel;
  logic                 a_ld;
  logic                 a_st;
  logic                 mem_hit;
  logic                 con_hit;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] widx;
  logic [31:0]          rdata;
  logic                 unused_addr_bits;

  assign accept = dm_ready_o & (dm_store_i | dm_load_i);

  // The access is performed on the accept edge when there are no wait states,
  // otherwise on the last wait cycle using the captured request.
  always_comb begin
    if (WAIT_STATES == 0) begin
      fire   = accept;
      a_addr = dm_addr_i;
      a_data = dm_data_s_i;
      a_sel  = dm_data_select_i;
      a_ld   = dm_load_i;
      a_st   = dm_store_i;
    end else begin
      fire   = (state == WAIT) && (wcnt == 4'(WAIT_STATES - 1));
      a_addr = addr_q;
      a_data = data_q;
      a_sel  = sel_q;
      a_ld   = ld_q;
      a_st   = st_q;
    end
  end

  assign mem_hit = (a_addr >> (ADDR_BITS + 2)) == 32'd0;
  assign widx    = a_addr[ADDR_BITS+1:2];
`ifdef URV_DM_CONSOLE_EN
  assign con_hit = (a_addr == CONSOLE_ADDR);
`else
  assign con_hit = 1'b0;
`endif
  // Word-aligned decode: the byte offset never matters.
  assign unused_addr_bits = ^a_addr[1:0];

  // Console takes priority should CONSOLE_ADDR ever alias into memory.
  assign mem_we = rst & fire & a_st & mem_hit & ~con_hit;

  // Load data: full word from memory, zero for console and out-of-range reads.
  always_comb begin
    rdata = 32'h0;
    if (mem_hit && !con_hit) rdata = mem[widx];
  end

  // Byte-lane writes; contents are deliberately left unreset.
  always_ff @(posedge wclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (a_sel[b]) mem[widx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  // Request FSM, wait-state counter and registered completion outputs.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      wcnt            <= 4'd0;
      addr_q          <= 32'h0;
      data_q          <= 32'h0;
      sel_q           <= 4'h0;
      ld_q            <= 1'b0;
      st_q            <= 1'b0;
      dm_ready_o      <= 1'b1;
      dm_data_l_o     <= 32'h0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_data_l_o     <= 32'h0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            addr_q <= dm_addr_i;
            data_q <= dm_data_s_i;
            sel_q  <= dm_data_select_i;
            ld_q   <= dm_load_i;
            st_q   <= dm_store_i;
            if (WAIT_STATES != 0) begin
              state      <= WAIT;
              wcnt       <= 4'd0;
              dm_ready_o <= 1'b0;
            end else begin
              state <= DONE;
            end
          end
        end
        WAIT: begin
          wcnt <= wcnt + 4'd1;
          if (fire) begin
            state      <= DONE;
            dm_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (fire) begin
        dm_load_done_o  <= a_ld;
        dm_store_done_o <= a_st;
        if (a_ld) dm_data_l_o <= rdata;
        if (!mem_hit && !con_hit) err_o <= 1'b1;
      end
    end
  end

`ifdef URV_DM_CONSOLE_EN
  // Console register: lane 0 only; 8'hFF also latches halt.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      console_data_o  <= 8'h0;
      console_valid_o <= 1'b0;
      halt_o          <= 1'b0;
    end else begin
      console_valid_o <= 1'b0;
      if (fire && a_st && con_hit && a_sel[0]) begin
        console_data_o  <= a_data[7:0];
        console_valid_o <= 1'b1;
        if (a_data[7:0] == 8'hFF) halt_o <= 1'b1;
      end
    end
  end
`else
  assign console_data_o  = 8'h0;
  assign console_valid_o = 1'b0;
  assign halt_o          = 1'b0;
`endif

endmodule

// File: tb/tb_urv_dm_responder.sv
// Bench for urv_dm_responder: three instances (0, 3 and 5 wait states) driven independently.
// Random traffic is checked against a word-level memory model kept in an associative array.
// Console expectations follow whether URV_DM_CONSOLE_EN is defined for this compile.
module tb_urv_dm_responder;

  localparam logic [31:0] CON = 32'h1000_0000;

  typedef struct {
    int          lat;
    int          low;
    logic [31:0] rd;
    logic        ldn;
    logic        sdn;
    logic        cv;
    logic        hl;
    logic        er;
    logic        after;
    logic [7:0]  cd;
  } obs_t;

  logic        wclk = 1'b0;
  logic        rst  [3];
  logic [31:0] addr [3];
  logic [31:0] sdat [3];
  logic [3:0]  sel  [3];
  logic        st   [3];
  logic        ld   [3];
  logic [31:0] ldat [3];
  logic        ldone[3];
  logic        sdone[3];
  logic        rdy  [3];
  logic [7:0]  cdat [3];
  logic        cval [3];
  logic        halt [3];
  logic        err  [3];

  int asserts = 0;
  int fails   = 0;
  logic [31:0] mm [int];

  always #5 wclk = ~wclk;

  urv_dm_responder #(.WAIT_STATES(0)) u_ws0 (
    .wclk(wclk), .rst(rst[0]), .dm_addr_i(addr[0]), .dm_data_s_i(sdat[0]),
    .dm_data_select_i(sel[0]), .dm_store_i(st[0]), .dm_load_i(ld[0]),
    .dm_data_l_o(ldat[0]), .dm_load_done_o(ldone[0]), .dm_store_done_o(sdone[0]),
    .dm_ready_o(rdy[0]), .console_data_o(cdat[0]), .console_valid_o(cval[0]),
    .halt_o(halt[0]), .err_o(err[0]));

  urv_dm_responder #(.WAIT_STATES(3)) u_ws3 (
    .wclk(wclk), .rst(rst[1]), .dm_addr_i(addr[1]), .dm_data_s_i(sdat[1]),
    .dm_data_select_i(sel[1]), .dm_store_i(st[1]), .dm_load_i(ld[1]),
    .dm_data_l_o(ldat[1]), .dm_load_done_o(ldone[1]), .dm_store_done_o(sdone[1]),
    .dm_ready_o(rdy[1]), .console_data_o(cdat[1]), .console_valid_o(cval[1]),
    .halt_o(halt[1]), .err_o(err[1]));

  urv_dm_responder #(.WAIT_STATES(5)) u_ws5 (
    .wclk(wclk), .rst(rst[2]), .dm_addr_i(addr[2]), .dm_data_s_i(sdat[2]),
    .dm_data_select_i(sel[2]), .dm_store_i(st[2]), .dm_load_i(ld[2]),
    .dm_data_l_o(ldat[2]), .dm_load_done_o(ldone[2]), .dm_store_done_o(sdone[2]),
    .dm_ready_o(rdy[2]), .console_data_o(cdat[2]), .console_valid_o(cval[2]),
    .halt_o(halt[2]), .err_o(err[2]));

  // ---------------- reference model (default ADDR_BITS = 12) ----------------
  function automatic bit is_con(input logic [31:0] a);
`ifdef URV_DM_CONSOLE_EN
    return a == CON;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit in_mem(input logic [31:0] a);
    return (a < 32'h0000_4000) && !is_con(a);
  endfunction

  function automatic int mkey(input int k, input logic [31:0] a);
    return k * 65536 + int'(a / 4);
  endfunction

  // Applies one access to the model; load result reflects the pre-store word.
  task automatic model_op(input int k, input bit l, input bit s, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m, output logic [31:0] rd);
    logic [31:0] w;
    rd = 32'h0;
    if (in_mem(a)) begin
      w = mm.exists(mkey(k, a)) ? mm[mkey(k, a)] : 32'hxxxx_xxxx;
      if (l) rd = w;
      if (s) begin
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        mm[mkey(k, a)] = w;
      end
    end
  endtask

  // Drives one request on instance k, waits for acceptance and completion.
  task automatic issue(input int k, input bit l, input bit s, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, output obs_t o);
    int w;
    o = '{lat: -1, low: 0, rd: 32'h0, ldn: 1'b0, sdn: 1'b0, cv: 1'b0, hl: 1'b0,
          er: 1'b0, after: 1'b0, cd: 8'h0};
    @(negedge wclk);
    addr[k] = a; sdat[k] = d; sel[k] = m; ld[k] = l; st[k] = s;
    w = 0;
    while (rdy[k] !== 1'b1 && w < 100) begin @(negedge wclk); w++; end
    @(posedge wclk); #1;
    ld[k] = 1'b0; st[k] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge wclk);
      if (rdy[k] !== 1'b1) o.low++;
      if (ldone[k] === 1'b1 || sdone[k] === 1'b1) begin
        o.lat = c; o.rd = ldat[k]; o.ldn = ldone[k]; o.sdn = sdone[k];
        o.cv = cval[k]; o.cd = cdat[k]; o.hl = halt[k]; o.er = err[k];
        break;
      end
    end
    @(negedge wclk);
    o.after = ldone[k] | sdone[k] | cval[k];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if ({rdy[k], ldone[k], sdone[k], cval[k], halt[k], err[k]} !== 6'b100000) begin
        fails++;
        $display("FAIL reset_flags[%0d]: got rdy/ld/sd/cv/halt/err=%b required 100000", k,
                 {rdy[k], ldone[k], sdone[k], cval[k], halt[k], err[k]});
      end
      asserts++;
      if ({ldat[k], cdat[k]} !== 40'h0) begin
        fails++;
        $display("FAIL reset_data[%0d]: got ldat=%h cdat=%h required 0", k, ldat[k], cdat[k]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    @(negedge wclk);
    addr[0] = 32'h10; sdat[0] = 32'hA5A5_1234; sel[0] = 4'hF; st[0] = 1'b1;
    model_op(0, 1'b0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, e);
    @(negedge wclk);
    asserts++;
    if ({sdone[0], ldone[0], rdy[0]} !== 3'b101) begin
      fails++; $display("FAIL basic_store: got sd/ld/rdy=%b required 101", {sdone[0], ldone[0], rdy[0]});
    end
    st[0] = 1'b0; ld[0] = 1'b1;
    @(negedge wclk);
    asserts++;
    if ({sdone[0], ldone[0], rdy[0]} !== 3'b011) begin
      fails++; $display("FAIL basic_load: got sd/ld/rdy=%b required 011", {sdone[0], ldone[0], rdy[0]});
    end
    asserts++;
    if (ldat[0] !== 32'hA5A5_1234) begin
      fails++; $display("FAIL basic_data: got %h required a5a51234", ldat[0]);
    end
    ld[0] = 1'b0;
  endtask

  task automatic test_lanes();
    obs_t o;
    logic [31:0] e;
    issue(0, 1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, o);
    model_op(0, 1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, e);
    issue(0, 1'b0, 1'b1, 32'h20, 32'hFFEE_DDCC, 4'b0101, o);
    model_op(0, 1'b0, 1'b1, 32'h20, 32'hFFEE_DDCC, 4'b0101, e);
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, o);
    asserts++;
    if (o.lat !== 1 || o.ldn !== 1'b1 || o.rd !== 32'h11EE_33CC) begin
      fails++; $display("FAIL lanes_0101: got lat=%0d data=%h required lat=1 data=11ee33cc", o.lat, o.rd);
    end
    issue(0, 1'b0, 1'b1, 32'h22, 32'h0BAD_0BAD, 4'b0000, o);
    asserts++;
    if (o.lat !== 1 || o.sdn !== 1'b1 || o.after !== 1'b0) begin
      fails++; $display("FAIL lanes_sel0_done: got lat=%0d sdn=%b after=%b required 1 1 0", o.lat, o.sdn, o.after);
    end
    issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, o);
    model_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, e);
    asserts++;
    if (o.rd !== e) begin
      fails++; $display("FAIL lanes_sel0_unchanged: got %h required %h", o.rd, e);
    end
  endtask

  task automatic test_rbw();
    obs_t o;
    logic [31:0] e;
    issue(0, 1'b0, 1'b1, 32'h30, 32'h0102_0304, 4'hF, o);
    model_op(0, 1'b0, 1'b1, 32'h30, 32'h0102_0304, 4'hF, e);
    issue(0, 1'b1, 1'b1, 32'h30, 32'hAABB_CCDD, 4'hF, o);
    model_op(0, 1'b1, 1'b1, 32'h30, 32'hAABB_CCDD, 4'hF, e);
    asserts++;
    if (o.ldn !== 1'b1 || o.sdn !== 1'b1 || o.rd !== e) begin
      fails++; $display("FAIL rbw_both: got ldn=%b sdn=%b data=%h required 1 1 %h", o.ldn, o.sdn, o.rd, e);
    end
    issue(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, o);
    asserts++;
    if (o.rd !== 32'hAABB_CCDD) begin
      fails++; $display("FAIL rbw_after: got %h required aabbccdd", o.rd);
    end
  endtask

  // Zero-wait instance: one random request per cycle, each checked one cycle later.
  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] e, ed, a, d;
    logic [3:0]  m;
    bit          el, es, pend;
    int          op;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      issue(0, 1'b0, 1'b1, 32'h100 + 32'(i * 4), d, 4'hF, o);
      model_op(0, 1'b0, 1'b1, 32'h100 + 32'(i * 4), d, 4'hF, e);
    end
    pend = 1'b0; el = 1'b0; es = 1'b0; ed = 32'h0;
    for (int i = 0; i <= 200; i++) begin
      @(negedge wclk);
      if (pend) begin
        asserts++;
        if (ldone[0] !== el || sdone[0] !== es || rdy[0] !== 1'b1) begin
          fails++;
          $display("FAIL b2b_flags[%0d]: got ld/sd/rdy=%b%b%b required %b%b1", i, ldone[0], sdone[0], rdy[0], el, es);
        end
        if (el) begin
          asserts++;
          if (ldat[0] !== ed) begin
            fails++; $display("FAIL b2b_data[%0d]: got %h required %h", i, ldat[0], ed);
          end
        end
      end
      if (i < 200) begin
        op = $urandom_range(0, 3);
        a  = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        d  = $urandom;
        m  = 4'($urandom_range(0, 15));
        el = (op == 1 || op == 3);
        es = (op == 2 || op == 3);
        model_op(0, el, es, a, d, m, ed);
        addr[0] = a; sdat[0] = d; sel[0] = m; ld[0] = el; st[0] = es;
        pend = 1'b1;
      end else begin
        ld[0] = 1'b0; st[0] = 1'b0; pend = 1'b0;
      end
    end
    asserts++;
    if (err[0] !== 1'b0) begin
      fails++; $display("FAIL b2b_err: got %b required 0", err[0]);
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    logic [31:0] e, d1, d2;
    int t1, t2, low1, low2;
    issue(1, 1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, o);
    model_op(1, 1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, e);
    asserts++;
    if (o.lat !== 4 || o.low !== 3 || o.sdn !== 1'b1) begin
      fails++; $display("FAIL ws3_store: got lat=%0d low=%0d required lat=4 low=3", o.lat, o.low);
    end
    issue(1, 1'b0, 1'b1, 32'h44, 32'h7777_1111, 4'hF, o);
    model_op(1, 1'b0, 1'b1, 32'h44, 32'h7777_1111, 4'hF, e);
    // Second load is held asserted through the first one's wait cycles.
    @(negedge wclk);
    addr[1] = 32'h40; ld[1] = 1'b1;
    @(posedge wclk); #1;
    addr[1] = 32'h44;
    t1 = -1; low1 = 0; d1 = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge wclk);
      if (rdy[1] !== 1'b1) low1++;
      if (ldone[1] === 1'b1) begin t1 = c; d1 = ldat[1]; break; end
    end
    @(posedge wclk); #1;
    ld[1] = 1'b0;
    t2 = -1; low2 = 0; d2 = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge wclk);
      if (rdy[1] !== 1'b1) low2++;
      if (ldone[1] === 1'b1) begin t2 = c; d2 = ldat[1]; break; end
    end
    asserts++;
    if (t1 !== 4 || low1 !== 3 || d1 !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL ws3_load1: got lat=%0d low=%0d data=%h required 4 3 0badf00d", t1, low1, d1);
    end
    asserts++;
    if (t2 !== 4 || low2 !== 3 || d2 !== 32'h7777_1111) begin
      fails++; $display("FAIL ws3_held: got lat=%0d low=%0d data=%h required 4 3 77771111", t2, low2, d2);
    end
  endtask

  task automatic test_random_wait();
    obs_t o;
    logic [31:0] e, a, d;
    logic [3:0]  m;
    bit          l, s;
    for (int i = 0; i < 8; i++) begin
      issue(1, 1'b0, 1'b1, 32'h400 + 32'(i * 4), 32'h0, 4'hF, o);
      model_op(1, 1'b0, 1'b1, 32'h400 + 32'(i * 4), 32'h0, 4'hF, e);
    end
    for (int i = 0; i < 30; i++) begin
      a = 32'h400 + 32'($urandom_range(0, 7) * 4);
      d = $urandom; m = 4'($urandom_range(0, 15));
      l = 1'($urandom_range(0, 1)); s = !l || ($urandom_range(0, 3) == 0);
      model_op(1, l, s, a, d, m, e);
      issue(1, l, s, a, d, m, o);
      asserts++;
      if (o.lat !== 4 || o.ldn !== l || o.sdn !== s || o.er !== 1'b0 || (l && o.rd !== e)) begin
        fails++;
        $display("FAIL ws3_random[%0d]: got lat=%0d ld/sd=%b%b data=%h required 4 %b%b %h", i, o.lat, o.ldn, o.sdn, o.rd, l, s, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    obs_t o;
    logic [31:0] e;
    issue(1, 1'b0, 1'b1, 32'h0, 32'hCAFE_0001, 4'hF, o);
    model_op(1, 1'b0, 1'b1, 32'h0, 32'hCAFE_0001, 4'hF, e);
    issue(1, 1'b0, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF, o);
    asserts++;
    if (o.lat !== 4 || o.sdn !== 1'b1 || o.er !== 1'b1) begin
      fails++; $display("FAIL oor_store: got lat=%0d sdn=%b err=%b required 4 1 1", o.lat, o.sdn, o.er);
    end
    issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, o);
    asserts++;
    if (o.rd !== 32'hCAFE_0001 || o.er !== 1'b1) begin
      fails++; $display("FAIL oor_unchanged: got data=%h err=%b required cafe0001 1", o.rd, o.er);
    end
    issue(1, 1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF, o);
    asserts++;
    if (o.ldn !== 1'b1 || o.rd !== 32'h0 || err[1] !== 1'b1) begin
      fails++; $display("FAIL oor_load: got ldn=%b data=%h err=%b required 1 0 1", o.ldn, o.rd, err[1]);
    end
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    logic [31:0] e;
    int pulses;
    issue(2, 1'b0, 1'b1, 32'h80, 32'h5EED_1234, 4'hF, o);
    model_op(2, 1'b0, 1'b1, 32'h80, 32'h5EED_1234, 4'hF, e);
    asserts++;
    if (o.lat !== 6 || o.low !== 5) begin
      fails++; $display("FAIL ws5_store: got lat=%0d low=%0d required 6 5", o.lat, o.low);
    end
    @(negedge wclk);
    addr[2] = 32'h84; ld[2] = 1'b1;
    @(posedge wclk); #1;
    ld[2] = 1'b0;
    repeat (2) @(negedge wclk);
    asserts++;
    if (rdy[2] !== 1'b0) begin
      fails++; $display("FAIL ws5_in_wait: got rdy=%b required 0", rdy[2]);
    end
    rst[2] = 1'b0;
    #1;
    asserts++;
    if ({rdy[2], ldone[2], sdone[2], cval[2], halt[2], err[2]} !== 6'b100000 || ldat[2] !== 32'h0) begin
      fails++; $display("FAIL ws5_reset_outputs: got flags=%b ldat=%h required 100000 0",
                        {rdy[2], ldone[2], sdone[2], cval[2], halt[2], err[2]}, ldat[2]);
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      if (c == 2) rst[2] = 1'b1;
      if (ldone[2] === 1'b1 || sdone[2] === 1'b1) pulses++;
    end
    asserts++;
    if (pulses !== 0 || rdy[2] !== 1'b1) begin
      fails++; $display("FAIL ws5_abandon: got pulses=%0d rdy=%b required 0 1", pulses, rdy[2]);
    end
    issue(2, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, o);
    model_op(2, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, e);
    asserts++;
    if (o.lat !== 6 || o.rd !== e) begin
      fails++; $display("FAIL ws5_retained: got lat=%0d data=%h required 6 %h", o.lat, o.rd, e);
    end
  endtask

  task automatic test_console();
    obs_t o1, o2, o3;
    asserts++;
    if (err[0] !== 1'b0 || halt[0] !== 1'b0) begin
      fails++; $display("FAIL con_pre: got err=%b halt=%b required 0 0", err[0], halt[0]);
    end
    issue(0, 1'b0, 1'b1, CON, 32'h0000_0048, 4'b0001, o1);
    issue(0, 1'b0, 1'b1, CON, 32'h1234_56FF, 4'b0001, o2);
    issue(0, 1'b1, 1'b0, CON, 32'h0, 4'hF, o3);
`ifdef URV_DM_CONSOLE_EN
    asserts++;
    if (o1.cv !== 1'b1 || o1.cd !== 8'h48 || o1.hl !== 1'b0 || o1.er !== 1'b0) begin
      fails++; $display("FAIL con_48: got cv=%b cd=%h halt=%b err=%b required 1 48 0 0", o1.cv, o1.cd, o1.hl, o1.er);
    end
    asserts++;
    if (o2.cv !== 1'b1 || o2.cd !== 8'hFF || o2.hl !== 1'b1 || o2.er !== 1'b0) begin
      fails++; $display("FAIL con_ff: got cv=%b cd=%h halt=%b err=%b required 1 ff 1 0", o2.cv, o2.cd, o2.hl, o2.er);
    end
    asserts++;
    if (o3.ldn !== 1'b1 || o3.rd !== 32'h0 || halt[0] !== 1'b1 || o3.cv !== 1'b0) begin
      fails++; $display("FAIL con_load: got ldn=%b data=%h halt=%b cv=%b required 1 0 1 0", o3.ldn, o3.rd, halt[0], o3.cv);
    end
`else
    asserts++;
    if (o1.cv !== 1'b0 || o1.er !== 1'b1 || o1.sdn !== 1'b1) begin
      fails++; $display("FAIL con_off_1: got cv=%b err=%b sdn=%b required 0 1 1", o1.cv, o1.er, o1.sdn);
    end
    asserts++;
    if (o2.cv !== 1'b0 || o2.hl !== 1'b0 || o2.er !== 1'b1 || o2.cd !== 8'h0) begin
      fails++; $display("FAIL con_off_2: got cv=%b halt=%b err=%b cd=%h required 0 0 1 00", o2.cv, o2.hl, o2.er, o2.cd);
    end
    asserts++;
    if (o3.ldn !== 1'b1 || o3.rd !== 32'h0 || halt[0] !== 1'b0) begin
      fails++; $display("FAIL con_off_load: got ldn=%b data=%h halt=%b required 1 0 0", o3.ldn, o3.rd, halt[0]);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; addr[k] = 32'h0; sdat[k] = 32'h0; sel[k] = 4'h0;
      st[k] = 1'b0; ld[k] = 1'b0;
    end
    repeat (3) @(negedge wclk);
    test_reset();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    @(negedge wclk);
    test_basic();
    test_lanes();
    test_rbw();
    test_back_to_back();
    test_wait_states();
    test_random_wait();
    test_out_of_range();
    test_reset_in_wait();
    test_console();
    repeat (2) @(negedge wclk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
